// File: rtl/alu_share_if.sv
// Request/response bundle between two ALU requesters, the share controller
// and the response consumer.
interface alu_share_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;

  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_op;
  logic [7:0] req1_a;
  logic [7:0] req1_b;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic [2:0] rsp_flags;

  logic [7:0] ops_done;
  logic       busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flags,
    output ops_done, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags,
    input  ops_done, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one 8-bit ALU between two valid/ready
// requesters, returning tagged results on a single response channel.
module alu_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] sel,
  output logic [7:0] result,
  output logic       carry,
  output logic       negative,
  output logic       zero
);
  logic [8:0] sum;

  // The adder subtracts whenever sel[2] is set, so CARRY becomes (a >= b).
  assign sum = {1'b0, a} + {1'b0, (sel[2] ? ~b : b)} + {8'd0, sel[2]};

  always_comb begin
    case (sel)
      3'b000:  result = sum[7:0];
      3'b001:  result = a & b;
      3'b010:  result = a | b;
      3'b011:  result = {a[6:0], 1'b0};
      3'b100:  result = a >> 1;
      default: result = 8'd0;
    endcase
  end

  assign carry    = sum[8];
  assign negative = result[7];
  assign zero     = (result == 8'd0);
endmodule

module alu_share_ctrl (
  input  logic         clk,
  input  logic         rst,
  alu_share_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       id_q, id_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] result_q, result_d;
  logic [2:0] flags_q, flags_d;
  logic [7:0] ops_done_q, ops_done_d;

  logic       grant_valid;
  logic       grant_id;
  logic       accept;
  logic [7:0] alu_result;
  logic       alu_carry, alu_negative, alu_zero;

  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant_q;
    else if (bus.req1_valid)              grant_id = 1'b1;
  end

  // Ready is held low while reset is asserted even though the state reads IDLE.
  assign accept         = ~rst & (state_q == S_IDLE) & grant_valid;
  assign bus.req0_ready = accept & ~grant_id;
  assign bus.req1_ready = accept &  grant_id;

  alu_8bit u_alu (
    .a        (a_q),
    .b        (b_q),
    .sel      (op_q),
    .result   (alu_result),
    .carry    (alu_carry),
    .negative (alu_negative),
    .zero     (alu_zero)
  );

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    flags_d      = flags_q;
    ops_done_d   = ops_done_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d         = grant_id;
          last_grant_d = grant_id;
          op_d         = grant_id ? bus.req1_op : bus.req0_op;
          a_d          = grant_id ? bus.req1_a  : bus.req0_a;
          b_d          = grant_id ? bus.req1_b  : bus.req0_b;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_result;
        flags_d  = {alu_carry, alu_negative, alu_zero};
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          ops_done_d = ops_done_q + 8'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: operand registers are reset too; they are few and it keeps outputs defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= 3'd0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      result_q     <= 8'd0;
      flags_q      <= 3'd0;
      ops_done_q   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.ops_done   = ops_done_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: accepted requests are pushed to a
// scoreboard with bench-computed results and popped on each response.
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst;

  alu_share_if bus ();

  alu_share_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic [2:0] flg;
    int         acc_cyc;
  } exp_t;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc_n       = 0;
  int         hs_n        = 0;
  int         hs0;
  logic [7:0] exp_done    = 8'd0;
  logic       exp_last    = 1'b1;
  logic       rsp_pend    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference ALU: returns {result, carry, negative, zero}.
  function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       c;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = {a[6:0], 1'b0};
      3'd4:    r = a >> 1;
      default: r = 8'd0;
    endcase
    c = op[2] ? (a >= b) : ((int'(a) + int'(b)) > 255);
    return {r, c, r[7], (r == 8'd0)};
  endfunction

  task automatic monitor();
    logic        acc0, acc1, exp_g;
    logic [10:0] m;
    exp_t        e;
    if (rst) return;
    chk("ops_done", 32'(bus.ops_done), 32'(exp_done));
    chk("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 0);
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
      end else begin
        if (!rsp_pend) begin
          chk("rsp_latency", 32'(cyc_n - sb[0].acc_cyc), 2);
          rsp_pend = 1'b1;
        end
        chk("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
        chk("rsp_result", 32'(bus.rsp_result), 32'(sb[0].res));
        chk("rsp_flags", 32'(bus.rsp_flags), 32'(sb[0].flg));
        if (bus.rsp_ready) begin
          void'(sb.pop_front());
          rsp_pend = 1'b0;
          exp_done = exp_done + 8'd1;
          hs_n++;
        end
      end
    end
    acc0 = bus.req0_valid & bus.req0_ready;
    acc1 = bus.req1_valid & bus.req1_ready;
    if (acc0 | acc1) begin
      exp_g = (bus.req0_valid && bus.req1_valid) ? ~exp_last : bus.req1_valid;
      chk("grant_id", 32'(acc1), 32'(exp_g));
      exp_last = exp_g;
      m = exp_g ? model(bus.req1_op, bus.req1_a, bus.req1_b)
                : model(bus.req0_op, bus.req0_a, bus.req0_b);
      e.id      = exp_g;
      e.res     = m[10:3];
      e.flg     = m[2:0];
      e.acc_cyc = cyc_n;
      sb.push_back(e);
    end
  endtask

  // Observe the settled cycle, then move to just after the next falling edge.
  task automatic adv();
    monitor();
    cyc_n++;
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    rsp_pend = 1'b0;
    exp_done = 8'd0;
    exp_last = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || sb.size() != 0) && n < 20) begin
      adv();
      n++;
    end
    chk("drain_timeout", 32'(bus.busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready0"},   32'(bus.req0_ready), 0);
    chk({tag, "_ready1"},   32'(bus.req1_ready), 0);
    chk({tag, "_rsp_valid"},32'(bus.rsp_valid),  0);
    chk({tag, "_rsp_id"},   32'(bus.rsp_id),     0);
    chk({tag, "_result"},   32'(bus.rsp_result), 0);
    chk({tag, "_flags"},    32'(bus.rsp_flags),  0);
    chk({tag, "_ops_done"}, 32'(bus.ops_done),   0);
    chk({tag, "_busy"},     32'(bus.busy),       0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 8'hF0; bus.req0_b = 8'h20;
    bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
    bus.rsp_ready  = 1'b1;
    @(negedge clk); #1;
    adv();
    chk_all_zero("reset");

    // Single request: F0 + 20 = 0x110.
    rst = 1'b0;
    #1;
    chk("t1_ready0", 32'(bus.req0_ready), 1);
    adv();
    bus.req0_valid = 1'b0;
    #1;
    chk("t1_exec_busy", 32'(bus.busy), 1);
    chk("t1_exec_rsp_valid", 32'(bus.rsp_valid), 0);
    adv();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t1_rsp_id", 32'(bus.rsp_id), 0);
    chk("t1_result", 32'(bus.rsp_result), 'h10);
    chk("t1_flags", 32'(bus.rsp_flags), 'b100);
    adv();
    chk("t1_ops_done", 32'(bus.ops_done), 1);
    chk("t1_idle", 32'(bus.busy), 0);

    // Back-pressure: 81 << 1 = 02, adder carry of 81 + 80 is 1.
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd3; bus.req1_a = 8'h81; bus.req1_b = 8'h80;
    #1;
    chk("t3_ready1", 32'(bus.req1_ready), 1);
    adv();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd4; bus.req0_a = 8'h01; bus.req0_b = 8'h01;
    #1;
    chk("t3_exec_ready0", 32'(bus.req0_ready), 0);
    adv();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(bus.rsp_valid), 1);
      chk("t3_hold_result", 32'(bus.rsp_result), 'h02);
      chk("t3_hold_flags", 32'(bus.rsp_flags), 'b100);
      chk("t3_hold_ready0", 32'(bus.req0_ready), 0);
      chk("t3_hold_ready1", 32'(bus.req1_ready), 0);
      adv();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t3_hs_valid", 32'(bus.rsp_valid), 1);
    adv();
    chk("t3_idle_after_hs", 32'(bus.busy), 0);
    chk("t3_accept_next", 32'(bus.req0_ready), 1);

    // Opcodes 100 (01 >> 1) then 101 (forced zero).
    adv();
    bus.req0_op = 3'd5; bus.req0_a = 8'hFF; bus.req0_b = 8'h00;
    #1;
    adv();
    chk("t4_op100_result", 32'(bus.rsp_result), 'h00);
    chk("t4_op100_flags", 32'(bus.rsp_flags), 'b101);
    adv();
    chk("t4_op101_ready0", 32'(bus.req0_ready), 1);
    adv();
    bus.req0_valid = 1'b0;
    #1;
    adv();
    chk("t4_op101_result", 32'(bus.rsp_result), 'h00);
    chk("t4_op101_flags", 32'(bus.rsp_flags), 'b101);
    wait_idle();

    // Reset during EXEC discards the operation.
    bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
    #1;
    chk("t5_ready0", 32'(bus.req0_ready), 1);
    adv();
    bus.req0_valid = 1'b0;
    #1;
    chk("t5_exec_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    model_reset();
    adv();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_rsp", 32'(bus.rsp_valid), 0);
      chk("t5_ops_done", 32'(bus.ops_done), 0);
      adv();
    end

    // Contention: requester 0 first after reset, then strict alternation.
    bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_a = 8'h3C; bus.req0_b = 8'h0F;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd2; bus.req1_a = 8'h3C; bus.req1_b = 8'h0F;
    #1;
    chk("t2_prio_ready0", 32'(bus.req0_ready), 1);
    chk("t2_prio_ready1", 32'(bus.req1_ready), 0);
    hs0 = hs_n;
    for (int i = 0; i < 40 && (hs_n - hs0) < 4; i++) adv();
    chk("t2_handshakes", 32'(hs_n - hs0), 4);
    adv();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    wait_idle();

    // ops_done wraps after 256 handshakes from reset.
    rst = 1'b1;
    #1;
    model_reset();
    adv();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 8'h01; bus.req0_b = 8'h01;
    #1;
    hs0 = hs_n;
    for (int i = 0; i < 900 && (hs_n - hs0) < 256; i++) begin
      if ((hs_n - hs0) == 255 && bus.rsp_valid) chk("t6_ops_done_255", 32'(bus.ops_done), 255);
      adv();
    end
    chk("t6_handshakes", 32'(hs_n - hs0), 256);
    chk("t6_ops_done_wrap", 32'(bus.ops_done), 0);
    adv();
    bus.req0_valid = 1'b0;
    #1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
